// File: rtl/adder_result_capture_if.sv
// Operand/result handshake bundle plus the hookup to the external ripple-carry adder.
// The master side is upstream plus the adder; the slave side is the capture stage.
interface adder_result_capture_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_ovf;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, out_ready, add_sum, add_ovf,
      input  in_ready, add_a, add_b, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready, add_sum, add_ovf,
      output in_ready, add_a, add_b, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/adder_result_capture.sv
// Sequences one operand pair through an external adder and captures the settled result.
// Latency: SETTLE_CYCLES edges from accept to out_valid; ADDER_SAT_EN clamps overflowed sums.
// Backpressure: one transaction in flight, in_ready low until the result is taken downstream.
module adder_result_capture #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int OVF_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_result_capture_if.slave bus,
   output logic [OVF_CNT_W-1:0] ovf_count,
   output logic                 busy
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     add_a_q;
   logic [WIDTH-1:0]     add_b_q;
   logic [WIDTH-1:0]     out_sum_q;
   logic                 out_ovf_q;
   logic [OVF_CNT_W-1:0] ovf_count_q;
   logic [WIDTH-1:0]     cap_sum;

   logic accept;
   logic capture;
   logic in_ready_c;
   logic out_valid_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      capture     = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            // Only the counter decides when the adder outputs are trusted.
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= CNT_LOAD;
      end else if (state_q == SETTLE && cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_a_q <= '0;
         add_b_q <= '0;
      end else if (accept) begin
         add_a_q <= bus.in_a;
         add_b_q <= bus.in_b;
      end
   end

`ifdef ADDER_SAT_EN
   // Signed overflow only happens when both operands share a sign, so A's MSB picks the rail.
   always_comb begin
      cap_sum = bus.add_sum;
      if (bus.add_ovf) begin
         cap_sum = add_a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign cap_sum = bus.add_sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum_q <= '0;
         out_ovf_q <= 1'b0;
      end else if (capture) begin
         out_sum_q <= cap_sum;
         out_ovf_q <= bus.add_ovf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_count_q <= '0;
      end else if (capture && bus.add_ovf && !(&ovf_count_q)) begin
         ovf_count_q <= ovf_count_q + OVF_CNT_W'(1);
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_ovf   = out_ovf_q;
   assign ovf_count     = ovf_count_q;
   assign busy          = (state_q != IDLE);

   a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      (state_q == HOLD && !bus.out_ready) |=> (state_q == HOLD && $stable(out_sum_q) && $stable(out_ovf_q)));

   a_cnt_range: assert property (@(posedge clk) disable iff (rst)
      (state_q == SETTLE) |-> (cnt_q <= CNT_LOAD));

endmodule

// File: doc/adder_result_capture.md
# adder_result_capture

- Sequencing and capture stage wrapped around the 4-bit ripple-carry adder.
- Accepts an operand pair over a valid/ready handshake and drives it into the adder's `a`/`b` inputs.
- Waits a programmable number of cycles for the gate-level carry chain to settle, then registers `sum`/`overflow`.
- Presents the result downstream over a second valid/ready handshake and keeps a saturating count of overflow events.

## Interface
Parameters:
- `WIDTH`, 4, operand/sum width; must match the adder instance.
- `SETTLE_CYCLES`, 2, cycles allowed for adder propagation; legal range ≥ 1.
- `OVF_CNT_W`, 8, width of overflow event counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept operands.
- `in_a`  in  WIDTH  operand A (two's complement).
- `in_b`  in  WIDTH  operand B (two's complement).
- `add_a`  out  WIDTH  registered operand A to adder `a`.
- `add_b`  out  WIDTH  registered operand B to adder `b`.
- `add_sum`  in  WIDTH  adder `sum`.
- `add_ovf`  in  1  adder `overflow` (signed overflow).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  WIDTH  captured (optionally saturated) sum.
- `out_ovf`  out  1  captured overflow flag.
- `ovf_count`  out  OVF_CNT_W  saturating count of overflowed results.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE
    - `in_ready`=1, combinational from state.
    - Transfer on `in_valid && in_ready`: `add_a`←`in_a`, `add_b`←`in_b`, `cnt`←SETTLE_CYCLES−1, go to SETTLE.
  - SETTLE
    - If `cnt`≠0: `cnt`←`cnt`−1.
    - If `cnt`==0: capture `out_sum`/`out_ovf` from `add_sum`/`add_ovf`, set `out_valid`, go to HOLD.
    - Capture is gated by the counter only; the adder inputs are never sampled early.
  - HOLD
    - `out_valid`=1; `out_sum`/`out_ovf` stable.
    - On `out_ready`: clear `out_valid`, go to IDLE.
- One transaction in flight; `in_ready`=0 in SETTLE and HOLD. `in_valid` in those states is ignored; upstream must hold it.
- `add_a`/`add_b` hold the last accepted operands until the next transfer.
- `ovf_count` increments by 1 at capture when `add_ovf`=1. It sticks at all-ones and does not wrap.
- Reset mid-operation: the FSM returns to IDLE and the in-flight transaction is discarded. No result is emitted.
- Reset values:
  - state IDLE, `cnt`=0.
  - `add_a`/`add_b`=0.
  - `out_valid`=0, `out_sum`=0, `out_ovf`=0.
  - `ovf_count`=0, `busy`=0.
  - `in_ready`=1.

## Timing
- Accept on edge T → SETTLE occupies SETTLE_CYCLES cycles → capture and `out_valid` rise on edge T+SETTLE_CYCLES.
- Requirement: SETTLE_CYCLES × clock period > worst-case adder delay through the NAND chain (1 ns per gate).
- Result leaves on the first edge with `out_ready`=1 in HOLD. If `out_ready` is already high, HOLD lasts 1 cycle.
- Minimum issue interval is SETTLE_CYCLES+2 cycles: SETTLE, HOLD, IDLE.
- `out_ready` asserted outside HOLD has no effect.

## Configuration
- Macro: `ADDER_SAT_EN`.
- Defined: when `add_ovf`=1 at capture, `out_sum` is clamped to the signed limit instead of the wrapped sum.
  - Latched `add_a` MSB = 0 → clamp to 0111.
  - Latched `add_a` MSB = 1 → clamp to 1000.
  - `out_ovf` and `ovf_count` still reflect the overflow.
- Undefined: `out_sum` = `add_sum` unmodified (wrap-around); no clamp logic is synthesized.

## Test plan
- Reset, then `in_a`=3, `in_b`=4, `out_ready`=1 → `out_valid` on edge T+2, `out_sum`=7, `out_ovf`=0, `ovf_count`=0.
- `in_a`=5, `in_b`=6 →
  - without macro: `out_sum`=1011, `out_ovf`=1, `ovf_count`=1.
  - with `ADDER_SAT_EN`: `out_sum`=0111.
- `in_a`=1000, `in_b`=1111 → `out_ovf`=1; `out_sum`=0111 wrapped, or 1000 with `ADDER_SAT_EN`.
- Hold `out_ready`=0 for 5 cycles with `in_valid`=1 →
  - `out_valid`, `out_sum`, `in_ready`=0 all stable.
  - Second operand accepted only after the `out_ready` handshake plus 1 IDLE cycle.
- Assert `rst` during SETTLE → all outputs return to reset values immediately; no `out_valid` pulse follows.
- Issue 260 overflowing additions (7+1) → `ovf_count` reaches 255 and stays there.
